// File: rtl/shim_spi_sts_reporter.sv
// Rising-edge event reporter for synchronized SPI-domain status groups: accumulates
// per-group pending masks and serializes them round-robin as timestamped AXI-stream words.
module shim_spi_sts_reporter #(
  parameter int NUM_GRP  = 15,
  parameter int TS_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [8*NUM_GRP-1:0] sts_flags,
  output logic [31:0]          m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [NUM_GRP-1:0]   pending_any,
  output logic                 irq
);

  // Handshake: m_tvalid rises only when a word is latched, then stays high with
  // m_tdata frozen until the cycle m_tready is sampled high; that cycle is the accept.

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [8*NUM_GRP-1:0] prev_q;
  logic [8*NUM_GRP-1:0] rise;
  logic [8*NUM_GRP-1:0] pend_q;
  logic [NUM_GRP-1:0]   coal_q;
  logic [TS_WIDTH-1:0]  ts_q;
  logic [4:0]           ptr_q;
  logic [31:0]          word_q;

  logic                 sel_found;
  logic [4:0]           sel;
  logic [NUM_GRP-1:0]   sel_oh;
  logic [7:0]           sel_mask;
  logic                 sel_coal;
  logic                 load;
  logic [NUM_GRP-1:0]   load_vec;

  assign rise = enable ? (sts_flags & ~prev_q) : '0;

  // Round-robin pick: first pass covers ptr..NUM_GRP-1, second pass wraps to 0..ptr-1.
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    sel_oh    = '0;
    sel_mask  = '0;
    sel_coal  = 1'b0;
    for (int g = 0; g < NUM_GRP; g++) begin
      if (!sel_found && (g >= int'(ptr_q)) && (pend_q[g*8 +: 8] != 8'h00)) begin
        sel_found  = 1'b1;
        sel        = 5'(g);
        sel_oh[g]  = 1'b1;
        sel_mask   = pend_q[g*8 +: 8];
        sel_coal   = coal_q[g];
      end
    end
    for (int g = 0; g < NUM_GRP; g++) begin
      if (!sel_found && (g < int'(ptr_q)) && (pend_q[g*8 +: 8] != 8'h00)) begin
        sel_found  = 1'b1;
        sel        = 5'(g);
        sel_oh[g]  = 1'b1;
        sel_mask   = pend_q[g*8 +: 8];
        sel_coal   = coal_q[g];
      end
    end
  end

  assign load     = (state_q == ST_IDLE) && enable && sel_found;
  assign load_vec = sel_oh & {NUM_GRP{load}};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load) state_d = ST_SEND;
      ST_SEND: if (m_tready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      prev_q  <= '0;
      ts_q    <= '0;
      ptr_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= sts_flags;
      ts_q    <= ts_q + 1'b1;
      if (load) begin
        word_q <= {sel_coal, 2'b00, sel, sel_mask, ts_q};
        if (int'(sel) == NUM_GRP - 1) ptr_q <= '0;
        else                          ptr_q <= sel + 5'd1;
      end
    end
  end

  // A rise landing on the load cycle survives because only the registered mask is cleared;
  // coalescing means the same bit rose again while still unreported.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pend_q <= '0;
      coal_q <= '0;
    end else if (clear) begin
      pend_q <= '0;
      coal_q <= '0;
    end else begin
      for (int g = 0; g < NUM_GRP; g++) begin
        pend_q[g*8 +: 8] <= (pend_q[g*8 +: 8] & {8{~load_vec[g]}}) | rise[g*8 +: 8];
        coal_q[g]        <= ~load_vec[g] & (coal_q[g] | (|(rise[g*8 +: 8] & pend_q[g*8 +: 8])));
      end
    end
  end

  always_comb begin
    pending_any = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      pending_any[g] = |pend_q[g*8 +: 8];
    end
  end

  assign m_tdata  = word_q;
  assign m_tvalid = (state_q == ST_SEND);
  assign irq      = (|pending_any) | m_tvalid;

endmodule

// File: doc/shim_spi_sts_reporter.md
# shim_spi_sts_reporter

Event reporter for the synchronized SPI-domain status flags on the AXI clock. It watches up to 32 8-bit status groups: SPI off, integrator threshold, trigger, DAC and ADC channel faults, with 1-bit flags zero-extended into their group. It detects rising edges and accumulates them as pending events per group. A round-robin scheduler serializes those events into timestamped 32-bit words on an AXI-stream master that feeds the PS-side status FIFO, and it raises an interrupt level while anything is outstanding.

## Interface
- NUM_GRP, 15, number of 8-bit status groups (1..32); group g occupies sts_flags[8g+7:8g]
- TS_WIDTH, 16, timestamp counter width (fixed at 16 in word format; other values illegal)
- aclk  in  1  AXI clock; the only clock
- areset  in  1  asynchronous, active-high reset
- enable  in  1  edge detection and scheduling enable
- clear  in  1  synchronous clear of all pending and coalesce state
- sts_flags  in  8*NUM_GRP  stable status flags, already synchronized to aclk
- m_tdata  out  32  event word
- m_tvalid  out  1  event word valid
- m_tready  in  1  downstream accept
- pending_any  out  NUM_GRP  per-group OR of pending bits
- irq  out  1  high while any pending bit is set or m_tvalid is high

## Operation
- Per-bit state:
  - prev: sts_flags registered every cycle.
  - rise = sts_flags & ~prev, gated by enable; rise is 0 when enable is low.
- Per-group state:
  - pend[g][7:0]: pend_next = (pend & ~load_mask) | rise.
  - coal[g]: set when (rise & pend) != 0 for that group, i.e. a bit rises again while still unreported.
- clear has priority over rise on the same cycle. It zeroes pend and coal; rises in that cycle are discarded.
- The free-running 16-bit counter ts counts from 0 after reset and wraps 0xFFFF -> 0x0000. It is unaffected by enable and clear.
- Word format:
  - [31] coal
  - [30:29] 0
  - [28:24] group index
  - [23:16] pending mask
  - [15:0] ts value at load
- FSM has two states, IDLE and SEND.
  - IDLE: if enable and any pend is nonzero, select the first group with nonzero pend, searching from ptr upward with wrap at NUM_GRP-1 -> 0.
  - On selection: latch the word, clear that group's pend (load_mask) and coal, set ptr <= sel+1 (wrapping), and go to SEND.
  - SEND: m_tvalid=1 and m_tdata held constant. On m_tready go to IDLE.
- The pend used for the load is the registered value. A rise on the load cycle for the selected group survives in pend and is reported in a later word.
- enable low during SEND does not abort the transfer. The word completes, then the FSM stays in IDLE; pend is retained.
- clear during SEND has the same rule: the current word is still delivered.
- pending_any[g] = |pend[g]. irq = (|pending_any) | m_tvalid.

## Timing
- Reset values:
  - m_tvalid=0, m_tdata=0, pending_any=0, irq=0
  - prev=0, ptr=0, ts=0, FSM=IDLE
- Because prev resets to 0, flags already high at reset release are reported once.
- Latency:
  - A flag high at edge k (prev=0) sets pend at edge k.
  - The word loads at edge k+1 if the FSM is in IDLE.
  - m_tvalid is high after edge k+1, i.e. two cycles from the input change.
- Throughput: at most one word per 2 cycles (IDLE, SEND). No back-to-back valid across words.
- AXI-stream rules apply: m_tvalid never drops without m_tready, and m_tdata is stable while m_tvalid && !m_tready.
- areset mid-transfer drops m_tvalid asynchronously. All pending events are lost.

## Test plan
- Single event:
  - Stimulus: reset, enable=1, set bit 3 of group 6 (DAC cal OOB), m_tready=1.
  - Required: one word 0x06_08_xxxx, with ts equal to the counter at load; m_tvalid high two cycles after the input edge, for exactly one cycle; irq falls after the accept.
- Round-robin:
  - Stimulus: rises in groups 0, 5 and 14 in the same cycle, with ptr=0.
  - Required: words issued for groups 0, 5, 14 in that order. A repeat rise on group 0 afterwards is served after 14 wraps, not ahead of 5.
- Backpressure and coalescing:
  - Stimulus: m_tready=0 while group 2 bit 0 rises, falls, then rises again, with pending already set for the second occurrence.
  - Required: the first word is held stable. The next word for group 2 has mask 0x01 and bit31=1.
- Load-cycle collision:
  - Stimulus: group 4 bit 1 pending, and group 4 bit 7 rises in the load cycle.
  - Required: first word mask 0x02; second word mask 0x80, bit31=0.
- clear and enable:
  - Stimulus: clear asserted during SEND with other groups pending.
  - Required: the current word completes, no further words follow, pending_any=0.
  - Stimulus: with enable=0, toggle flags.
  - Required: no words, pend unchanged.
- Reset and wrap:
  - Stimulus: flags preset high through areset.
  - Required: one word per such group after release.
  - Stimulus: run 65536 cycles.
  - Required: ts wraps to 0x0000 in word[15:0].
  - Stimulus: areset during SEND.
  - Required: m_tvalid=0 immediately.
